matrix_entry_loader: RTL and testbench
======================================

Name: matrix_entry_loader

Overview:
- Upstream stage of the determinant datapath.
- Captures signed matrix elements one at a time from the switch bank, each on a debounced single-clock load pulse, into an N x N register array in row-major order.
- Raises a valid/ack handshake to the downstream determinant engine once the array is full.
- Exposes a 1-cycle-latency read port the engine uses to fetch elements, plus cursor and last-entry outputs for SSD/LED display.

Parameters:
- N, 8, matrix dimension (rows = columns); N >= 2.
- W, 8, element width in bits, two's complement.

Ports:
- Clk  in  1  system clock (100 MHz board clock).
- Reset  in  1  synchronous, active-high reset.
- Load_Pulse  in  1  single-cycle pulse; write Sw_Data at the cursor.
- Sw_Data  in  W  element value from the switches, signed.
- Mat_Ack  in  1  single-cycle pulse from the engine; matrix consumed.
- Rd_Row  in  clog2(N)  engine read row index.
- Rd_Col  in  clog2(N)  engine read column index.
- Rd_Data  out  W  element at (Rd_Row, Rd_Col), registered.
- Mat_Valid  out  1  high while the full matrix is held for the engine.
- Cur_Row  out  clog2(N)  row index of the next write.
- Cur_Col  out  clog2(N)  column index of the next write.
- Entry_Count  out  clog2(N*N)+1  number of elements written in the current fill.
- Last_Entry  out  W  most recently written value, for the SSDs.
- q_Init, q_Fill, q_Ready  out  1 each  one-hot state flags, for the LEDs.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - State = INIT; Cur_Row, Cur_Col, Entry_Count, Last_Entry, Rd_Data all 0; Mat_Valid 0.
  - Array loaded with the identity matrix: element (i,i) = 1, all other elements = 0.
- Reset mid-fill or while in READY aborts the fill, takes effect on the next edge, and overrides every other input.
- States:
  - INIT: waiting for the first element. Cursor is (0,0). The array holds its previous contents.
  - FILL: a partial matrix is being entered.
  - READY: the array is full and Mat_Valid = 1.
- Write in INIT or FILL, on Load_Pulse:
  - array[Cur_Row][Cur_Col] <= Sw_Data; Last_Entry <= Sw_Data; Entry_Count += 1.
  - Cursor advances row-major: Cur_Col increments. When Cur_Col = N-1 it wraps to 0 and Cur_Row increments.
  - If the write lands at (N-1, N-1): Entry_Count = N*N, cursor wraps to (0,0), next state READY.
  - Otherwise INIT moves to FILL and FILL stays in FILL.
- READY:
  - Mat_Valid is held high; Load_Pulse is ignored, so the array is frozen.
  - Mat_Ack moves to INIT with Entry_Count = 0. The array is not cleared; the next fill overwrites it entry by entry.
  - Load_Pulse and Mat_Ack in the same cycle: Ack wins and the load is dropped.
- Mat_Ack outside READY is ignored.
- Mat_Valid is registered and goes high on the same edge the last element is written.
- Read port:
  - Rd_Data <= array[Rd_Row][Rd_Col] every cycle, in any state, giving 1-cycle latency.
  - Reads are valid data only while Mat_Valid = 1.
- Write and read to the same cell in the same cycle: Rd_Data returns the old value (read-before-write).
- Sw_Data is stored verbatim; no sign extension or saturation is applied.

Optional Feature:
- Macro: MATRIX_ENTRY_LOADER_BACKSTEP_EN.
- When defined:
  - Adds input Back_Pulse (1 bit, single-cycle pulse).
  - In FILL, Back_Pulse retreats the cursor by one position (row-major), decrements Entry_Count, and writes that cell back to its identity value. When Entry_Count reaches 0, the state returns to INIT.
  - In INIT and READY, Back_Pulse is ignored.
  - Load_Pulse and Back_Pulse in the same cycle: Load wins.
- When undefined: no Back_Pulse port; entries can only be corrected by a full Reset.

Decomposition:
- Shared package ee354_det_pkg:
  - constants N_DEFAULT = 8, W_DEFAULT = 8;
  - element typedef (signed logic [W-1:0]);
  - loader state enum {INIT, FILL, READY};
  - index typedef sized clog2(N).
- The engine imports the same package.
- One natural sub-module, matrix_cursor: a row-major row/column counter with advance, retreat and clear inputs and a wrap flag at (N-1, N-1).
- The array storage stays inline.

Test Plan:
- Reset then read all 64 cells -> Rd_Data = 1 on the diagonal and 0 elsewhere, each 1 cycle after the address is applied; q_Init = 1.
- Apply 64 Load_Pulses with Sw_Data = 0x01..0x40 -> Mat_Valid rises on the edge of the 64th pulse; cell (2,3) reads 0x14; Entry_Count = 64; cursor (0,0).
- In READY, apply Load_Pulse with Sw_Data = 0xFF -> array unchanged, Last_Entry still 0x40; then Mat_Ack -> q_Init = 1, Mat_Valid = 0, cell (0,0) still 0x01.
- In READY, assert Load_Pulse and Mat_Ack in the same cycle -> state INIT, Entry_Count = 0, no cell written.
- Write 10 entries, then assert Reset -> next cycle INIT, cursor (0,0), Entry_Count = 0, array back to identity.
- With BACKSTEP_EN: write 0x7F at (0,7) and 0x80 at (1,0), then Back_Pulse -> cursor (1,0), Entry_Count = 8, cell (1,0) = 0, Last_Entry = 0x80.

Source files
------------

// File: rtl/matrix_entry_loader_pkg.sv
// Shared determinant-datapath types: element/index typedefs and the loader state enum.
// The loader's optional backstep feature is gated by MATRIX_ENTRY_LOADER_BACKSTEP_EN.
package ee354_det_pkg;
  localparam int unsigned N_DEFAULT = 8;
  localparam int unsigned W_DEFAULT = 8;

  typedef logic signed [W_DEFAULT-1:0]  elem_t;
  typedef logic [$clog2(N_DEFAULT)-1:0] idx_t;

  typedef enum logic [1:0] {
    INIT,
    FILL,
    READY
  } state_t;
endpackage

// File: rtl/matrix_entry_loader_if.sv
// Loader <-> engine/switch-bank bus; Back_Pulse exists only with MATRIX_ENTRY_LOADER_BACKSTEP_EN.
interface matrix_entry_loader_if #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned CW = $clog2(N*N) + 1;

  logic          Load_Pulse;
  logic [W-1:0]  Sw_Data;
  logic          Mat_Ack;
  logic [IW-1:0] Rd_Row;
  logic [IW-1:0] Rd_Col;
  logic [W-1:0]  Rd_Data;
  logic          Mat_Valid;
  logic [IW-1:0] Cur_Row;
  logic [IW-1:0] Cur_Col;
  logic [CW-1:0] Entry_Count;
  logic [W-1:0]  Last_Entry;
  logic          q_Init;
  logic          q_Fill;
  logic          q_Ready;
`ifdef MATRIX_ENTRY_LOADER_BACKSTEP_EN
  logic          Back_Pulse;

  modport master (
    output Load_Pulse, Sw_Data, Mat_Ack, Rd_Row, Rd_Col, Back_Pulse,
    input  Rd_Data, Mat_Valid, Cur_Row, Cur_Col, Entry_Count, Last_Entry,
           q_Init, q_Fill, q_Ready
  );
  modport slave (
    input  Load_Pulse, Sw_Data, Mat_Ack, Rd_Row, Rd_Col, Back_Pulse,
    output Rd_Data, Mat_Valid, Cur_Row, Cur_Col, Entry_Count, Last_Entry,
           q_Init, q_Fill, q_Ready
  );
`else
  modport master (
    output Load_Pulse, Sw_Data, Mat_Ack, Rd_Row, Rd_Col,
    input  Rd_Data, Mat_Valid, Cur_Row, Cur_Col, Entry_Count, Last_Entry,
           q_Init, q_Fill, q_Ready
  );
  modport slave (
    input  Load_Pulse, Sw_Data, Mat_Ack, Rd_Row, Rd_Col,
    output Rd_Data, Mat_Valid, Cur_Row, Cur_Col, Entry_Count, Last_Entry,
           q_Init, q_Fill, q_Ready
  );
`endif
endinterface

// File: rtl/matrix_entry_loader_cursor.sv
// Row-major write cursor for the matrix loader (used by both builds of
// MATRIX_ENTRY_LOADER_BACKSTEP_EN); o_wrap flags the last cell (N-1, N-1).
module matrix_cursor #(
  parameter int unsigned N = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic          i_ret,
  output logic [IW-1:0] o_row,
  output logic [IW-1:0] o_col,
  output logic          o_wrap
);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [IW-1:0] r_row;
  logic [IW-1:0] r_col;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (r_col == LAST) begin
        r_col <= '0;
        r_row <= (r_row == LAST) ? '0 : r_row + IW'(1);
      end else begin
        r_col <= r_col + IW'(1);
      end
    end else if (i_ret) begin
      if (r_col == '0) begin
        r_col <= LAST;
        r_row <= r_row - IW'(1);
      end else begin
        r_col <= r_col - IW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_wrap = (r_row == LAST) && (r_col == LAST);
endmodule

// File: rtl/matrix_entry_loader.sv
// N x N signed-element loader with valid/ack handoff and registered read port.
// Define MATRIX_ENTRY_LOADER_BACKSTEP_EN to add Back_Pulse entry undo.
module matrix_entry_loader
  import ee354_det_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned W = W_DEFAULT
) (
  input logic                  Clk,
  input logic                  Reset,
  matrix_entry_loader_if.slave bus
);
  localparam int unsigned   IW   = $clog2(N);
  localparam int unsigned   CW   = $clog2(N*N) + 1;
  localparam logic [CW-1:0] FULL = CW'(N*N);

  state_t        r_state;
  logic [W-1:0]  r_mem [N][N];
  logic [W-1:0]  r_rd;
  logic [W-1:0]  r_last;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_q_init, r_q_fill, r_q_ready;

  logic          w_load, w_ack, w_back, w_wrap;
  logic [IW-1:0] w_row, w_col;

  assign w_load = bus.Load_Pulse && (r_state != READY);
  assign w_ack  = bus.Mat_Ack && (r_state == READY);
`ifdef MATRIX_ENTRY_LOADER_BACKSTEP_EN
  logic [IW-1:0] w_prev_row, w_prev_col;
  assign w_back     = bus.Back_Pulse && !bus.Load_Pulse && (r_state == FILL);
  assign w_prev_row = (w_col == '0) ? w_row - IW'(1) : w_row;
  assign w_prev_col = (w_col == '0) ? IW'(N - 1) : w_col - IW'(1);
`else
  assign w_back = 1'b0;
`endif

  matrix_cursor #(.N(N)) u_cursor (
    .i_clk  (Clk),
    .i_clr  (Reset),
    .i_adv  (w_load),
    .i_ret  (w_back),
    .o_row  (w_row),
    .o_col  (w_col),
    .o_wrap (w_wrap)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= INIT;
      r_count <= '0;
      r_last  <= '0;
      r_valid <= 1'b0;
      {r_q_init, r_q_fill, r_q_ready} <= 3'b100;
    end else begin
      case (r_state)
        INIT, FILL: begin
          if (w_load) begin
            r_last <= bus.Sw_Data;
            if (w_wrap) begin
              r_state <= READY;
              r_count <= FULL;
              r_valid <= 1'b1;
              {r_q_init, r_q_fill, r_q_ready} <= 3'b001;
            end else begin
              r_state <= FILL;
              r_count <= r_count + CW'(1);
              {r_q_init, r_q_fill, r_q_ready} <= 3'b010;
            end
          end else if (w_back) begin
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state <= INIT;
              {r_q_init, r_q_fill, r_q_ready} <= 3'b100;
            end
          end
        end
        READY: begin
          if (w_ack) begin
            r_state <= INIT;
            r_count <= '0;
            r_valid <= 1'b0;
            {r_q_init, r_q_fill, r_q_ready} <= 3'b100;
          end
        end
        default: begin
          r_state <= INIT;
          {r_q_init, r_q_fill, r_q_ready} <= 3'b100;
        end
      endcase
    end
  end

  // Read samples the pre-edge array, so a same-cell write returns the old value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_rd <= '0;
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          r_mem[i][j] <= (i == j) ? W'(1) : '0;
    end else begin
      r_rd <= r_mem[bus.Rd_Row][bus.Rd_Col];
      if (w_load)
        r_mem[w_row][w_col] <= bus.Sw_Data;
`ifdef MATRIX_ENTRY_LOADER_BACKSTEP_EN
      else if (w_back)
        r_mem[w_prev_row][w_prev_col] <= (w_prev_row == w_prev_col) ? W'(1) : '0;
`endif
    end
  end

  assign bus.Rd_Data     = r_rd;
  assign bus.Mat_Valid   = r_valid;
  assign bus.Cur_Row     = w_row;
  assign bus.Cur_Col     = w_col;
  assign bus.Entry_Count = r_count;
  assign bus.Last_Entry  = r_last;
  assign bus.q_Init      = r_q_init;
  assign bus.q_Fill      = r_q_fill;
  assign bus.q_Ready     = r_q_ready;
endmodule

// File: tb/tb_matrix_entry_loader.sv
// Directed scoreboard bench for matrix_entry_loader (N=8, W=8);
// extra backstep steps when MATRIX_ENTRY_LOADER_BACKSTEP_EN is defined.
module tb_matrix_entry_loader;
  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_entry_loader_if #(.N(N), .W(W)) bus ();
  matrix_entry_loader #(.N(N), .W(W)) dut (.Clk(clk), .Reset(rst), .bus(bus));

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  model [N][N];
  logic [7:0]  exp_q [$];
  int unsigned idx;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [2:0] q, input logic v,
                              input int unsigned r, input int unsigned c,
                              input int unsigned n, input logic [7:0] last);
    check({tag, ".q"},     {bus.q_Init, bus.q_Fill, bus.q_Ready}, q);
    check({tag, ".valid"}, bus.Mat_Valid, v);
    check({tag, ".row"},   bus.Cur_Row, r);
    check({tag, ".col"},   bus.Cur_Col, c);
    check({tag, ".count"}, bus.Entry_Count, n);
    check({tag, ".last"},  bus.Last_Entry, last);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        model[i][j] = (i == j) ? 8'h01 : 8'h00;
    idx = 0;
  endtask

  task automatic load(input logic [7:0] v);
    bus.Load_Pulse = 1'b1;
    bus.Sw_Data    = v;
    tick();
    bus.Load_Pulse = 1'b0;
    model[idx / N][idx % N] = v;
    idx = (idx + 1) % (N * N);
  endtask

  task automatic read_cell(input string tag, input int unsigned r, input int unsigned c);
    bus.Rd_Row = 3'(r);
    bus.Rd_Col = 3'(c);
    exp_q.push_back(model[r][c]);
    tick();
    check($sformatf("%s(%0d,%0d)", tag, r, c), bus.Rd_Data, exp_q.pop_front());
  endtask

  task automatic read_all(input string tag);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        read_cell(tag, r, c);
  endtask

`ifdef MATRIX_ENTRY_LOADER_BACKSTEP_EN
  task automatic back();
    bus.Back_Pulse = 1'b1;
    tick();
    bus.Back_Pulse = 1'b0;
    idx = idx - 1;
    model[idx / N][idx % N] = ((idx / N) == (idx % N)) ? 8'h01 : 8'h00;
  endtask
`endif

  initial begin
    bus.Load_Pulse = 1'b0;
    bus.Sw_Data    = '0;
    bus.Mat_Ack    = 1'b0;
    bus.Rd_Row     = '0;
    bus.Rd_Col     = '0;
`ifdef MATRIX_ENTRY_LOADER_BACKSTEP_EN
    bus.Back_Pulse = 1'b0;
`endif
    rst = 1'b1;
    tick();
    tick();
    check("rst.rd", bus.Rd_Data, 0);
    check_status("rst", 3'b100, 1'b0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    model_reset();
    read_all("ident");

    // First fill 0x01..0x40
    for (int v = 1; v <= 64; v++) begin
      load(8'(v));
      if (v == 1)  check_status("fill1", 3'b010, 1'b0, 0, 1, 1, 8'h01);
      if (v == 63) check_status("fill63", 3'b010, 1'b0, 7, 7, 63, 8'h3F);
    end
    check_status("full", 3'b001, 1'b1, 0, 0, 64, 8'h40);
    read_cell("c23", 2, 3);

    // Load ignored while READY
    bus.Load_Pulse = 1'b1;
    bus.Sw_Data    = 8'hFF;
    tick();
    bus.Load_Pulse = 1'b0;
    check_status("ready_load", 3'b001, 1'b1, 0, 0, 64, 8'h40);
    read_all("frozen");

    bus.Mat_Ack = 1'b1;
    tick();
    bus.Mat_Ack = 1'b0;
    check_status("ack", 3'b100, 1'b0, 0, 0, 0, 8'h40);
    read_cell("c00_after_ack", 0, 0);

    // Second fill with negative values; stray ack mid-fill is ignored
    for (int v = 0; v < 64; v++) begin
      load(8'(8'h80 + v));
      if (v == 4) begin
        bus.Mat_Ack = 1'b1;
        tick();
        bus.Mat_Ack = 1'b0;
        check_status("ack_in_fill", 3'b010, 1'b0, 0, 5, 5, 8'h84);
      end
    end
    check_status("full2", 3'b001, 1'b1, 0, 0, 64, 8'hBF);
    bus.Load_Pulse = 1'b1;
    bus.Sw_Data    = 8'h33;
    bus.Mat_Ack    = 1'b1;
    tick();
    bus.Load_Pulse = 1'b0;
    bus.Mat_Ack    = 1'b0;
    check_status("ack_wins", 3'b100, 1'b0, 0, 0, 0, 8'hBF);
    read_all("ack_wins");

    // Ten boundary values, then same-cell read/write at (1,2)
    for (int v = 0; v < 10; v++) load((v % 2 == 0) ? 8'h7F : 8'h80);
    bus.Rd_Row     = 3'd1;
    bus.Rd_Col     = 3'd2;
    exp_q.push_back(model[1][2]);
    bus.Load_Pulse = 1'b1;
    bus.Sw_Data    = 8'h55;
    tick();
    bus.Load_Pulse = 1'b0;
    check("rbw_old", bus.Rd_Data, exp_q.pop_front());
    model[1][2] = 8'h55;
    idx = idx + 1;
    read_cell("rbw_new", 1, 2);
    check_status("partial", 3'b010, 1'b0, 1, 3, 11, 8'h55);

    rst = 1'b1;
    tick();
    check("rst2.rd", bus.Rd_Data, 0);
    check_status("rst2", 3'b100, 1'b0, 0, 0, 0, 8'h00);
    rst = 1'b0;
    model_reset();
    read_all("rst_ident");

`ifdef MATRIX_ENTRY_LOADER_BACKSTEP_EN
    for (int v = 1; v <= 7; v++) load(8'(v));
    load(8'h7F);
    load(8'h80);
    check_status("pre_back", 3'b010, 1'b0, 1, 1, 9, 8'h80);
    back();
    check_status("back1", 3'b010, 1'b0, 1, 0, 8, 8'h80);
    read_cell("back_c10", 1, 0);
    read_cell("back_c07", 0, 7);
    bus.Load_Pulse = 1'b1;
    bus.Back_Pulse = 1'b1;
    bus.Sw_Data    = 8'h22;
    tick();
    bus.Load_Pulse = 1'b0;
    bus.Back_Pulse = 1'b0;
    model[idx / N][idx % N] = 8'h22;
    idx = idx + 1;
    check_status("load_wins", 3'b010, 1'b0, 1, 1, 9, 8'h22);
    for (int k = 0; k < 9; k++) back();
    check_status("back_to_init", 3'b100, 1'b0, 0, 0, 0, 8'h22);
    bus.Back_Pulse = 1'b1;
    tick();
    bus.Back_Pulse = 1'b0;
    check_status("back_in_init", 3'b100, 1'b0, 0, 0, 0, 8'h22);
    read_all("back_ident");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
